// File: rtl/mem_line_controller_pkg.sv
// Shared encodings for the memory line controller: FSM states, op kinds and
// the memory-mapped I/O base address.
package mem_line_controller_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_LINE_READ  = 3'd1;
   localparam logic [2:0] ST_LINE_WRITE = 3'd2;
   localparam logic [2:0] ST_IO_READ    = 3'd3;
   localparam logic [2:0] ST_IO_WRITE   = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_LINE_READ  = ST_LINE_READ,
      S_LINE_WRITE = ST_LINE_WRITE,
      S_IO_READ    = ST_IO_READ,
      S_IO_WRITE   = ST_IO_WRITE,
      S_DONE       = ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_FILL = 2'd0,
      OP_WB   = 2'd1,
      OP_IORD = 2'd2,
      OP_IOWR = 2'd3
   } op_t;

   localparam logic [31:0] IO_ADDR = 32'h0003_0000;

endpackage

// File: rtl/mem_line_controller_line_shift_buffer.sv
// Line assembly buffer: one byte written per cycle at an index, whole line
// visible on the output and held until overwritten.
module line_shift_buffer #(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                    clkIn,
   input  logic                    resetIn,
   input  logic                    i_we,
   input  logic [BLOCK_WIDTH-1:0]  i_idx,
   input  logic [7:0]              i_byte,
   output logic [BLOCK_SIZE*8-1:0] o_line
);

   logic [BLOCK_SIZE-1:0][7:0] r_bytes;

   always_ff @(posedge clkIn or posedge resetIn) begin
      if (resetIn) begin
         r_bytes <= '0;
      end else if (i_we) begin
         r_bytes[i_idx] <= i_byte;
      end
   end

   assign o_line = r_bytes;

endmodule

// File: rtl/mem_line_controller.sv
// Memory-side responder for cache line fills, write-backs and byte I/O,
// serialised onto a byte-wide synchronous RAM/IO bus.
module mem_line_controller
   import mem_line_controller_pkg::*;
#(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
   input  logic                    clkIn,
   input  logic                    resetIn,
   input  logic                    clearIn,
   input  logic                    missIn,
   input  logic [31-BLOCK_WIDTH:0] missAddrIn,
   input  logic                    readWriteIn,
   input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
   input  logic                    ioReqIn,
   input  logic                    ioReadWriteIn,
   input  logic [31:0]             ioAddrIn,
   input  logic [7:0]              ioDataIn,
   input  logic                    ioBufferFull,
   input  logic [7:0]              ramDataIn,
   output logic                    memDataValid,
   output logic [31-BLOCK_WIDTH:0] memAddr,
   output logic [BLOCK_SIZE*8-1:0] memDataOut,
   output logic                    acceptWrite,
   output logic                    mutableMemInValid,
   output logic [31:0]             mutableMemDataOut,
   output logic                    mutableWriteSuc,
   output logic [31:0]             ramAddr,
   output logic [7:0]              ramDataOut,
   output logic                    ramWrite
);

   localparam int KW = BLOCK_WIDTH + 1;
   localparam logic [KW-1:0] K_LAST = KW'(BLOCK_SIZE - 1);
   localparam logic [KW-1:0] K_END  = KW'(BLOCK_SIZE);

   state_t                  r_state, w_next;
   op_t                     r_op;
   logic [KW-1:0]           r_k;
   logic [31-BLOCK_WIDTH:0] r_lineAddr;
   logic [BLOCK_SIZE*8-1:0] r_wbLine;
   logic [31:0]             r_ioAddr;
   logic [7:0]              r_ioData;
   logic [7:0]              r_ioRdData;
   logic                    w_takeMiss;
   logic                    w_fillWe;
   logic [BLOCK_WIDTH-1:0]  w_fillIdx;

   // A flush in IDLE only blocks a fill; write-backs and I/O still go.
   assign w_takeMiss = missIn && !(readWriteIn && clearIn);

   // Byte returned on cycle k belongs to address k-1; wraps to the last byte at k = BLOCK_SIZE.
   assign w_fillIdx = r_k[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
   assign w_fillWe  = (r_state == S_LINE_READ) && (r_k != '0) && !clearIn;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ioReqIn)         w_next = ioReadWriteIn ? S_IO_READ : S_IO_WRITE;
            else if (w_takeMiss) w_next = readWriteIn ? S_LINE_READ : S_LINE_WRITE;
         end
         S_LINE_READ: begin
            if (clearIn)          w_next = S_IDLE;
            else if (r_k == K_END) w_next = S_DONE;
         end
         S_LINE_WRITE: if (r_k == K_LAST) w_next = S_DONE;
         S_IO_READ:    if (r_k != '0)     w_next = S_DONE;
         S_IO_WRITE:   if (!ioBufferFull) w_next = S_DONE;
         S_DONE:       w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      ramAddr           = '0;
      ramDataOut        = '0;
      ramWrite          = 1'b0;
      memDataValid      = 1'b0;
      acceptWrite       = 1'b0;
      mutableMemInValid = 1'b0;
      mutableWriteSuc   = 1'b0;
      case (r_state)
         S_LINE_READ: begin
            if (r_k != K_END) ramAddr = {r_lineAddr, r_k[BLOCK_WIDTH-1:0]};
         end
         S_LINE_WRITE: begin
            ramAddr    = {r_lineAddr, r_k[BLOCK_WIDTH-1:0]};
            ramDataOut = r_wbLine[8*r_k[BLOCK_WIDTH-1:0] +: 8];
            ramWrite   = 1'b1;
         end
         S_IO_READ: begin
            if (r_k == '0) ramAddr = r_ioAddr;
         end
         S_IO_WRITE: begin
            if (!ioBufferFull) begin
               ramAddr    = r_ioAddr;
               ramDataOut = r_ioData;
               ramWrite   = 1'b1;
            end
         end
         S_DONE: begin
            case (r_op)
               OP_FILL: memDataValid      = 1'b1;
               OP_WB:   acceptWrite       = 1'b1;
               OP_IORD: mutableMemInValid = 1'b1;
               default: mutableWriteSuc   = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clkIn or posedge resetIn) begin
      if (resetIn) begin
         r_state    <= S_IDLE;
         r_op       <= OP_FILL;
         r_k        <= '0;
         r_lineAddr <= '0;
         r_wbLine   <= '0;
         r_ioAddr   <= '0;
         r_ioData   <= '0;
         r_ioRdData <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               r_k <= '0;
               if (ioReqIn) begin
                  r_op     <= ioReadWriteIn ? OP_IORD : OP_IOWR;
                  r_ioAddr <= ioAddrIn;
                  r_ioData <= ioDataIn;
               end else if (w_takeMiss) begin
                  r_op       <= readWriteIn ? OP_FILL : OP_WB;
                  r_lineAddr <= missAddrIn;
                  r_wbLine   <= writeBackIn;
               end
            end
            S_LINE_READ, S_LINE_WRITE: r_k <= r_k + KW'(1);
            S_IO_READ: begin
               r_k <= r_k + KW'(1);
               if (r_k != '0) r_ioRdData <= ramDataIn;
            end
            default: ;
         endcase
      end
   end

   line_shift_buffer #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BLOCK_SIZE  (BLOCK_SIZE)
   ) u_fill_buf (
      .clkIn   (clkIn),
      .resetIn (resetIn),
      .i_we    (w_fillWe),
      .i_idx   (w_fillIdx),
      .i_byte  (ramDataIn),
      .o_line  (memDataOut)
   );

   assign memAddr           = r_lineAddr;
   assign mutableMemDataOut = {24'd0, r_ioRdData};

endmodule

// File: tb/tb_mem_line_controller.sv
// Scoreboard bench for mem_line_controller: expected bus cycles and completion
// pulses are queued at stimulus time and retired by a negedge monitor.
module tb_mem_line_controller;
   import mem_line_controller_pkg::*;

   localparam int BW = 4;
   localparam int BS = 16;
   localparam int EV_FILL = 1, EV_WB = 2, EV_IORD = 3, EV_IOWR = 4;
   localparam logic [127:0] LINE_INC = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] LINE_WB  = 128'hFFEEDDCCBBAA99887766554433221100;

   typedef struct {
      int            kind;
      logic [27:0]   addr;
      logic [127:0]  data;
   } evt_t;

   logic          clkIn = 0, resetIn = 1, clearIn = 0, missIn = 0, readWriteIn = 0;
   logic          ioReqIn = 0, ioReadWriteIn = 0, ioBufferFull = 0;
   logic [31-BW:0] missAddrIn = '0;
   logic [127:0]  writeBackIn = '0;
   logic [31:0]   ioAddrIn = '0;
   logic [7:0]    ioDataIn = '0, ramDataIn = '0;
   logic          memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc, ramWrite;
   logic [31-BW:0] memAddr;
   logic [127:0]  memDataOut;
   logic [31:0]   mutableMemDataOut, ramAddr;
   logic [7:0]    ramDataOut;

   int n_chk = 0, n_err = 0;
   int n_wr = 0, n_fill = 0, n_wb = 0;
   logic [39:0] wr_q[$];
   logic [31:0] rd_q[$];
   evt_t        evt_q[$];
   logic [39:0] m_wr;
   logic [31:0] m_rd;
   evt_t        m_ev;

   mem_line_controller #(.BLOCK_WIDTH(BW)) dut (
      .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .missIn(missIn),
      .missAddrIn(missAddrIn), .readWriteIn(readWriteIn), .writeBackIn(writeBackIn),
      .ioReqIn(ioReqIn), .ioReadWriteIn(ioReadWriteIn), .ioAddrIn(ioAddrIn),
      .ioDataIn(ioDataIn), .ioBufferFull(ioBufferFull), .ramDataIn(ramDataIn),
      .memDataValid(memDataValid), .memAddr(memAddr), .memDataOut(memDataOut),
      .acceptWrite(acceptWrite), .mutableMemInValid(mutableMemInValid),
      .mutableMemDataOut(mutableMemDataOut), .mutableWriteSuc(mutableWriteSuc),
      .ramAddr(ramAddr), .ramDataOut(ramDataOut), .ramWrite(ramWrite)
   );

   always #5 clkIn = ~clkIn;

   // RAM returns the low address byte; the I/O location returns 8'h7A.
   always @(posedge clkIn) ramDataIn <= (ramAddr == IO_ADDR) ? 8'h7A : ramAddr[7:0];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic take_evt(input int kind, input logic [127:0] data, input logic [27:0] addr,
                           input bit use_data, input bit use_addr);
      if (evt_q.size() == 0) begin
         check("pulse_unexpected", 128'(kind), 128'd0);
      end else begin
         m_ev = evt_q.pop_front();
         check("evt_kind", 128'(kind), 128'(m_ev.kind));
         if (use_data) check("evt_data", data, m_ev.data);
         if (use_addr) check("evt_addr", 128'(addr), 128'(m_ev.addr));
      end
   endtask

   always @(negedge clkIn) begin
      if (!resetIn) begin
         if (ramWrite) begin
            n_wr++;
            if (wr_q.size() == 0) check("ramWrite_unexpected", 128'(ramWrite), 128'd0);
            else begin
               m_wr = wr_q.pop_front();
               check("ram_wr", 128'({ramAddr, ramDataOut}), 128'(m_wr));
            end
         end else if (ramAddr != 32'd0) begin
            if (rd_q.size() == 0) check("rd_unexpected", 128'(ramAddr), 128'd0);
            else begin
               m_rd = rd_q.pop_front();
               check("rd_addr", 128'(ramAddr), 128'(m_rd));
            end
         end
         if (memDataValid) begin
            n_fill++;
            take_evt(EV_FILL, memDataOut, memAddr, 1'b1, 1'b1);
         end
         if (acceptWrite) begin
            n_wb++;
            take_evt(EV_WB, '0, memAddr, 1'b0, 1'b1);
         end
         if (mutableMemInValid) take_evt(EV_IORD, 128'(mutableMemDataOut), '0, 1'b1, 1'b0);
         if (mutableWriteSuc)   take_evt(EV_IOWR, '0, '0, 1'b0, 1'b0);
      end
   end

   // Counts negedges until the selected pulse is seen; 200 means it never came.
   task automatic wait_pulse(input int sel, output int cnt);
      bit hit;
      hit = 0;
      cnt = 0;
      while (!hit && cnt < 200) begin
         @(negedge clkIn);
         case (sel)
            0:       hit = memDataValid;
            1:       hit = acceptWrite;
            2:       hit = mutableMemInValid;
            default: hit = mutableWriteSuc;
         endcase
         if (!hit) cnt++;
      end
   endtask

   task automatic step();
      @(posedge clkIn);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cnt, base;
      #3;
      check("rst_ramWrite", 128'(ramWrite), 128'd0);
      check("rst_ramAddr", 128'(ramAddr), 128'd0);
      check("rst_ramDataOut", 128'(ramDataOut), 128'd0);
      check("rst_pulses", 128'({memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc}), 128'd0);
      check("rst_memDataOut", memDataOut, 128'd0);
      check("rst_memAddr", 128'(memAddr), 128'd0);
      check("rst_mutableMemDataOut", 128'(mutableMemDataOut), 128'd0);
      repeat (2) @(posedge clkIn);
      #1 resetIn = 0;
      step();

      // line fill
      missAddrIn = 28'h00010; readWriteIn = 1; missIn = 1;
      for (int k = 0; k < BS; k++) rd_q.push_back(32'h100 + k);
      evt_q.push_back('{EV_FILL, 28'h00010, LINE_INC});
      wait_pulse(0, cnt);
      check("fill_latency", 128'(cnt), 128'd18);
      step();
      missIn = 0;
      repeat (3) step();
      check("fill_hold", memDataOut, LINE_INC);

      // write-back
      base = n_wr;
      missAddrIn = 28'h00020; readWriteIn = 0; writeBackIn = LINE_WB; missIn = 1;
      for (int k = 0; k < BS; k++) wr_q.push_back({32'h200 + k, 8'(k * 17)});
      evt_q.push_back('{EV_WB, 28'h00020, '0});
      wait_pulse(1, cnt);
      check("wb_latency", 128'(cnt), 128'd17);
      step();
      missIn = 0;
      repeat (3) step();
      check("wb_write_count", 128'(n_wr - base), 128'd16);

      // flush during fill byte 5
      base = n_fill;
      missAddrIn = 28'h00030; readWriteIn = 1; missIn = 1;
      for (int k = 0; k < 6; k++) rd_q.push_back(32'h300 + k);
      repeat (6) step();
      clearIn = 1; missIn = 0;
      step();
      clearIn = 0;
      check("flush_idle_addr", 128'(ramAddr), 128'd0);
      repeat (25) step();
      check("flush_no_valid", 128'(n_fill - base), 128'd0);

      // I/O write stalled by a full buffer
      base = n_wr;
      ioAddrIn = IO_ADDR; ioDataIn = 8'h41; ioReadWriteIn = 0; ioBufferFull = 1; ioReqIn = 1;
      wr_q.push_back({IO_ADDR, 8'h41});
      evt_q.push_back('{EV_IOWR, '0, '0});
      repeat (4) step();
      check("iowr_stall_ramWrite", 128'(ramWrite), 128'd0);
      ioBufferFull = 0;
      wait_pulse(3, cnt);
      check("iowr_latency", 128'(cnt), 128'd1);
      step();
      ioReqIn = 0;
      repeat (2) step();
      check("iowr_once", 128'(n_wr - base), 128'd1);

      // I/O read has priority over a pending fill
      ioAddrIn = IO_ADDR; ioReadWriteIn = 1; ioReqIn = 1;
      missAddrIn = 28'h00040; readWriteIn = 1; missIn = 1;
      rd_q.push_back(IO_ADDR);
      for (int k = 0; k < BS; k++) rd_q.push_back(32'h400 + k);
      evt_q.push_back('{EV_IORD, '0, 128'h7A});
      evt_q.push_back('{EV_FILL, 28'h00040, LINE_INC});
      wait_pulse(2, cnt);
      check("iord_latency", 128'(cnt), 128'd3);
      check("iord_data", 128'(mutableMemDataOut), 128'h7A);
      step();
      ioReqIn = 0;
      wait_pulse(0, cnt);
      check("fill_after_io", 128'(cnt), 128'd18);
      step();
      missIn = 0;
      repeat (2) step();
      check("iord_hold", 128'(mutableMemDataOut), 128'h7A);

      // asynchronous reset in the middle of a write-back
      base = n_wb;
      missAddrIn = 28'h00050; readWriteIn = 0; writeBackIn = LINE_WB; missIn = 1;
      for (int k = 0; k < 3; k++) wr_q.push_back({32'h500 + k, 8'(k * 17)});
      repeat (4) step();
      #2;
      resetIn = 1; missIn = 0;
      #1;
      check("rst_mid_ramWrite", 128'(ramWrite), 128'd0);
      check("rst_mid_ramAddr", 128'(ramAddr), 128'd0);
      step();
      resetIn = 0;
      repeat (25) step();
      check("rst_no_accept", 128'(n_wb - base), 128'd0);

      check("wr_q_empty", 128'(wr_q.size()), 128'd0);
      check("rd_q_empty", 128'(rd_q.size()), 128'd0);
      check("evt_q_empty", 128'(evt_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mem_line_controller.md
Name: mem_line_controller

Overview:
Memory-side responder for the data cache's miss/write-back protocol. Accepts a line-fill or line-write-back request, or a byte-wide I/O access, and serialises it onto the byte-wide synchronous RAM/IO bus. It returns a full line, a write-back acknowledge, or an I/O result to the cache. It sits between the data cache and the top-level memory port.

Parameters:
BLOCK_WIDTH, 4, log2 of line size in bytes
BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes

Ports:
clkIn  input  1  system clock
resetIn  input  1  reset; asynchronous, active-high
clearIn  input  1  wrong-branch flush
missIn  input  1  cache line request (level, held until serviced)
missAddrIn  input  32-BLOCK_WIDTH  line address [31:BLOCK_WIDTH]
readWriteIn  input  1  1 = line fill, 0 = write-back
writeBackIn  input  BLOCK_SIZE*8  line to write back; byte k in bits [8k+7:8k]
ioReqIn  input  1  I/O access request (level)
ioReadWriteIn  input  1  1 = read, 0 = write
ioAddrIn  input  32  I/O byte address
ioDataIn  input  8  I/O write byte
ioBufferFull  input  1  I/O sink cannot accept a write
ramDataIn  input  8  byte returned by RAM/IO, one cycle after its address
memDataValid  output  1  one-cycle pulse: fill line valid
memAddr  output  32-BLOCK_WIDTH  line address for memDataValid/acceptWrite
memDataOut  output  BLOCK_SIZE*8  filled line
acceptWrite  output  1  one-cycle pulse: write-back complete
mutableMemInValid  output  1  one-cycle pulse: I/O read byte valid
mutableMemDataOut  output  32  I/O read byte, zero-extended
mutableWriteSuc  output  1  one-cycle pulse: I/O write done
ramAddr  output  32  bus byte address
ramDataOut  output  8  bus write byte
ramWrite  output  1  1 = write this cycle

Behaviour:
- Reset (async): state IDLE. All pulses, ramWrite, ramAddr, ramDataOut, memDataOut, memAddr and mutableMemDataOut are 0.
- States: IDLE, LINE_READ, LINE_WRITE, IO_READ, IO_WRITE, DONE.
- IDLE arbitration: ioReqIn has priority over missIn, and both are sampled only in IDLE.
  - Request latches address/data/direction; next cycle enters the op state.
  - Byte counter k = 0; line base = {missAddrIn, BLOCK_WIDTH'b0}.
- LINE_READ:
  - Cycle k (0..BLOCK_SIZE-1): ramAddr = base+k, ramWrite = 0.
  - ramDataIn captured into byte k-1 on cycle k, and into byte BLOCK_SIZE-1 on cycle BLOCK_SIZE.
  - Enters DONE after that cycle.
  - Fill latency: BLOCK_SIZE+2 cycles from request acceptance to memDataValid (18 for default).
- LINE_WRITE: cycle k drives ramAddr = base+k, ramDataOut = byte k, ramWrite = 1. After k = BLOCK_SIZE-1, enters DONE.
- IO_READ: one address cycle (ramWrite = 0); byte captured the following cycle; then DONE.
- IO_WRITE:
  - Waits while ioBufferFull = 1 (ramWrite = 0).
  - First cycle with ioBufferFull = 0: ramWrite = 1, ramAddr = ioAddrIn, ramDataOut = ioDataIn.
  - Then DONE.
- DONE: for exactly one cycle, asserts the pulse matching the op, with memAddr = latched line address; then IDLE.
  - memDataOut and mutableMemDataOut hold their last value until overwritten.
- ramWrite is 0 in every state other than the LINE_WRITE/IO_WRITE write cycles.
- clearIn:
  - In LINE_READ: abort, no memDataValid, IDLE next cycle.
  - In IDLE: a pending fill is not accepted that cycle.
  - LINE_WRITE, IO_READ and IO_WRITE are never aborted; their completion pulses are still issued.
- A request held across DONE is re-sampled in IDLE, so the minimum gap between ops is one IDLE cycle.
- Address arithmetic is 32-bit; base+k never carries past the line, because base is line-aligned.

Decomposition:
- Shared package: state encoding localparams and the IO address constant 32'h30000, for bench use.
- Optional sub-module line_shift_buffer: BLOCK_SIZE-byte buffer with indexed byte load and byte select.

Test Plan:
- Fill: RAM byte at addr A = A[7:0]; missIn = 1, readWriteIn = 1, missAddrIn = 28'h00010. Required: ramAddr 0x100..0x10F, memDataValid 18 cycles later, memDataOut = 128'h0F0E0D0C0B0A09080706050403020100, memAddr = 28'h00010.
- Write-back: writeBackIn = 128'hFFEE..00, missAddrIn = 28'h00020, readWriteIn = 0. Required: 16 write cycles at 0x200..0x20F with bytes 00..FF, then one acceptWrite pulse.
- Flush: clearIn pulse during fill byte 5. Required: no memDataValid, IDLE next cycle, ramWrite never 1.
- IO write with ioBufferFull = 1 for 3 cycles, ioAddrIn = 0x30000, ioDataIn = 8'h41. Required: ramWrite = 1 exactly once, after full drops, then mutableWriteSuc.
- IO read of 0x30000 returning 8'h7A, with missIn also high. Required: IO is serviced first with mutableMemDataOut = 32'h7A; the fill starts after DONE and one IDLE cycle.
- resetIn asserted mid write-back, asynchronously. Required: ramWrite = 0 immediately, and no acceptWrite.
